// File: rtl/mips_boot_pkg.sv
// Shared types and helpers for the MIPS boot/run/dump controller.
package mips_boot_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StArmed,
    StRun,
    StDumpRf,
    StDumpDm,
    StDone
  } boot_state_e;

  localparam logic DUMP_SEL_REG = 1'b0;
  localparam logic DUMP_SEL_MEM = 1'b1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/mips_dump_streamer.sv
// Index counter and valid/ready sequencing for one dump pass of programmable length.
module mips_dump_streamer #(
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [IDX_W:0]   len,
  input  logic             ready,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic             last_fire
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             fire;

  always_comb begin
    valid     = en;
    idx       = idx_q;
    fire      = en && ready;
    last_fire = fire && ({1'b0, idx_q} == len - (IDX_W + 1)'(1));
    idx_d     = idx_q;
    // Wrap to zero on the final word so the next pass starts cleanly.
    if (!en || last_fire) begin
      idx_d = '0;
    end else if (fire) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/mips_boot_dump_ctrl.sv
// Load/run/dump controller: boots the core from a stream, runs it, then streams state out.
module mips_boot_dump_ctrl
  import mips_boot_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned RF_DEPTH   = 32,
  parameter int unsigned DM_DUMP    = 16,
  parameter int unsigned CNT_W      = 16,
  parameter bit          HALT_EN    = 1'b1,
  parameter logic [31:0] HALT_PC    = 32'hFFFF_FFFC,
  parameter int unsigned IA_W       = clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              start,
  input  logic [CNT_W-1:0]  run_cycles,
  output logic              imem_we,
  output logic [IA_W-1:0]   imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              cpu_en,
  input  logic [31:0]       pc_in,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [IA_W-1:0]   dm_raddr,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_sel,
  output logic [IA_W-1:0]   dump_idx,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [IA_W:0] IMEM_FULL = (IA_W + 1)'(IMEM_DEPTH);
  localparam logic [IA_W:0] RF_LEN    = (IA_W + 1)'(RF_DEPTH);
  localparam logic [IA_W:0] DM_LEN    = (IA_W + 1)'(DM_DUMP);

  boot_state_e      state_q, state_d;
  logic [IA_W:0]    wptr_q, wptr_d, wr_addr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;
  logic             ld_fire, halt_hit;
  logic             str_en, str_valid, str_last;
  logic [IA_W:0]    str_len;
  logic [IA_W-1:0]  str_idx;

  always_comb begin
    ld_ready   = !reset && (state_q inside {StIdle, StLoad, StDone});
    ld_fire    = ld_valid && ld_ready;
    // A fresh program always lands at address 0, even when re-entering from DONE.
    wr_addr    = (state_q inside {StIdle, StDone}) ? '0 : wptr_q;
    imem_we    = ld_fire && (wr_addr < IMEM_FULL);
    imem_waddr = wr_addr[IA_W-1:0];
    imem_wdata = ld_data;
    halt_hit   = HALT_EN && (pc_in == HALT_PC);

    cpu_reset  = reset || (state_q inside {StIdle, StLoad, StArmed});
    // The halting instruction itself must not execute.
    cpu_en     = !reset && (state_q == StRun) && !halt_hit;

    str_en     = !reset && (state_q inside {StDumpRf, StDumpDm});
    str_len    = (state_q == StDumpDm) ? DM_LEN : RF_LEN;
    dump_valid = str_valid;
    dump_idx   = str_idx;
    dump_sel   = (state_q == StDumpDm) ? DUMP_SEL_MEM : DUMP_SEL_REG;
    dump_data  = (dump_sel == DUMP_SEL_MEM) ? dm_rdata : rf_rdata;
    rf_raddr   = 5'(str_idx);
    dm_raddr   = str_idx;

    busy       = !reset && !(state_q inside {StIdle, StDone});
    done       = !reset && (state_q == StDone);
    error      = !reset && error_q;
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    case (state_q)
      StIdle, StLoad, StDone: begin
        if (ld_fire) begin
          if (imem_we) begin
            wptr_d = wr_addr + (IA_W + 1)'(1);
          end else begin
            wptr_d  = wr_addr;
            error_d = 1'b1;
          end
          state_d = ld_last ? StArmed : StLoad;
        end
      end
      StArmed: begin
        if (start) begin
          cnt_d   = run_cycles;
          state_d = (run_cycles == '0) ? StDumpRf : StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (halt_hit || (cnt_q == CNT_W'(1))) begin
          state_d = StDumpRf;
        end
      end
      StDumpRf: if (str_last) state_d = StDumpDm;
      StDumpDm: if (str_last) state_d = StDone;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  mips_dump_streamer #(
    .IDX_W (IA_W)
  ) u_streamer (
    .clk       (clk),
    .reset     (reset),
    .en        (str_en),
    .len       (str_len),
    .ready     (dump_ready),
    .valid     (str_valid),
    .idx       (str_idx),
    .last_fire (str_last)
  );

endmodule

// File: tb/tb_mips_boot_dump_ctrl.sv
// Scoreboard bench for mips_boot_dump_ctrl: random programs, run lengths, halts and stalls.
module tb_mips_boot_dump_ctrl;

  localparam logic [31:0] HALT_PC = 32'hFFFF_FFFC;
  localparam int          NO_HALT = 1 << 30;

  logic        clk = 1'b0;
  logic        reset, ld_valid, ld_ready, ld_last, start, imem_we, cpu_reset, cpu_en;
  logic        dump_valid, dump_ready, dump_sel, busy, done, error;
  logic [31:0] ld_data, imem_wdata, pc_in, rf_rdata, dm_rdata, dump_data;
  logic [15:0] run_cycles;
  logic [5:0]  imem_waddr, dm_raddr, dump_idx;
  logic [4:0]  rf_raddr;

  logic [31:0] rf_mem[32];
  logic [31:0] dm_mem[64];
  logic [31:0] enc[5] = '{32'h0022_1820, 32'h8C04_0004, 32'hAC04_0008, 32'h1063_0001,
                          32'h0062_2822};

  logic [37:0] imem_q[$];
  logic [38:0] dump_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          en_cnt = 0;
  int          halt_lim = NO_HALT;
  int          stall_left = 0;
  bit          stall_arm = 1'b0;
  bit          err_m = 1'b0;

  assign rf_rdata = rf_mem[rf_raddr];
  assign dm_rdata = dm_mem[dm_raddr];

  always #5 clk = ~clk;

  mips_boot_dump_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .start      (start),
    .run_cycles (run_cycles),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .cpu_en     (cpu_en),
    .pc_in      (pc_in),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .dm_raddr   (dm_raddr),
    .dm_rdata   (dm_rdata),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_sel   (dump_sel),
    .dump_idx   (dump_idx),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every imem write and every presented dump word is matched against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (imem_we) begin
        if (imem_q.size() == 0) check("imem_unexpected", 64'(imem_waddr), 64'h0bad);
        else check("imem_write", {imem_waddr, imem_wdata}, imem_q.pop_front());
      end
      if (dump_valid) begin
        if (dump_q.size() == 0) begin
          check("dump_unexpected", {dump_sel, dump_idx, dump_data}, 64'h0bad);
        end else begin
          check("dump_word", {dump_sel, dump_idx, dump_data}, dump_q[0]);
          if (dump_ready) void'(dump_q.pop_front());
        end
      end
      if (cpu_en) en_cnt++;
    end
  end

  // Core PC model: advances per enabled edge, jumps to the halt address after halt_lim edges.
  always @(posedge clk) begin
    #1;
    pc_in = (en_cnt >= halt_lim) ? HALT_PC : 32'(en_cnt * 4);
  end

  // Dump sink: random backpressure, plus one forced 3-cycle stall at register index 7.
  always @(posedge clk) begin
    #1;
    if (stall_left > 0) begin
      dump_ready = 1'b0;
      stall_left--;
    end else if (stall_arm && dump_valid && !dump_sel && dump_idx == 6'd7) begin
      dump_ready = 1'b0;
      stall_left = 2;
      stall_arm  = 1'b0;
    end else begin
      dump_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic load(input int n, input bit use_enc);
    for (int k = 0; k < n; k++) begin
      logic [31:0] d;
      d        = (use_enc && k < 5) ? enc[k] : $urandom;
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = (k == n - 1);
      if (k < 64) imem_q.push_back({6'(k), d});
      @(negedge clk);
      check("ld_ready", 64'(ld_ready), 64'd1);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    if (n > 64) err_m = 1'b1;
    @(negedge clk);
    check("armed_ld_ready", 64'(ld_ready), 64'd0);
    check("armed_cpu_reset", 64'(cpu_reset), 64'd1);
    check("error_flag", 64'(error), 64'(err_m));
    check("imem_writes_left", 64'(imem_q.size()), 64'd0);
    imem_q.delete();
    tick();
  endtask

  task automatic expect_dump();
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    for (int i = 0; i < 64; i++) dm_mem[i] = $urandom;
    for (int i = 0; i < 32; i++) dump_q.push_back({1'b0, 6'(i), rf_mem[i]});
    for (int i = 0; i < 16; i++) dump_q.push_back({1'b1, 6'(i), dm_mem[i]});
  endtask

  task automatic launch(input int cyc, input int hlim);
    @(negedge clk);
    en_cnt   = 0;
    halt_lim = hlim;
    tick();
    // ld_valid alongside start must be ignored.
    start      = 1'b1;
    run_cycles = 16'(cyc);
    ld_valid   = 1'b1;
    ld_data    = $urandom;
    ld_last    = 1'b1;
    @(negedge clk);
    check("armed_start_ready", 64'(ld_ready), 64'd0);
    tick();
    start    = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic run(input int cyc, input int hlim, input int exp_en, input bit stall);
    bit ok;
    expect_dump();
    stall_arm = stall;
    launch(cyc, hlim);
    @(negedge clk);
    if (cyc == 0) check("dump_immediate", 64'(dump_valid), 64'd1);
    else check("cpu_reset_in_run", 64'(cpu_reset), 64'd0);
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_reached", 64'(ok), 64'd1);
    if (!ok) dump_q.delete();
    check("cpu_en_cycles", 64'(en_cnt), 64'(exp_en));
    check("busy_in_done", 64'(busy), 64'd0);
    check("cpu_en_in_done", 64'(cpu_en), 64'd0);
    check("dump_words_left", 64'(dump_q.size()), 64'd0);
    tick();
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b1;
    @(negedge clk);
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
    check({tag, "_dump_valid"}, 64'(dump_valid), 64'd0);
    check({tag, "_imem_we"}, 64'(imem_we), 64'd0);
    check({tag, "_cpu_en"}, 64'(cpu_en), 64'd0);
    tick();
    reset = 1'b0;
    err_m = 1'b0;
    dump_q.delete();
    @(negedge clk);
    check({tag, "_idle_ready"}, 64'(ld_ready), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_post_cpu_reset"}, 64'(cpu_reset), 64'd1);
    tick();
  endtask

  initial begin
    bit ok;
    reset      = 1'b1;
    ld_valid   = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    start      = 1'b0;
    run_cycles = '0;
    dump_ready = 1'b0;
    pc_in      = '0;
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    for (int i = 0; i < 64; i++) dm_mem[i] = '0;
    tick();
    @(negedge clk);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_cpu_en", 64'(cpu_en), 64'd0);
    check("rst_ld_ready", 64'(ld_ready), 64'd0);
    check("rst_dump_valid", 64'(dump_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    tick();
    reset = 1'b0;

    load(5, 1'b1);
    run(4, NO_HALT, 4, 1'b1);

    load(65, 1'b0);
    run(0, NO_HALT, 0, 1'b0);

    load(3, 1'b0);
    run(100, 2, 2, 1'b0);

    for (int r = 0; r < 4; r++) begin
      int n, c;
      n = $urandom_range(1, 10);
      c = $urandom_range(0, 7);
      load(n, 1'b0);
      run(c, NO_HALT, c, 1'b0);
    end

    load(3, 1'b0);
    launch(100, NO_HALT);
    repeat (4) tick();
    reset_pulse("rst_run");

    load(2, 1'b0);
    expect_dump();
    launch(1, NO_HALT);
    ok = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (dump_valid && dump_sel) begin
        ok = 1'b1;
        break;
      end
    end
    check("reached_dump_dm", 64'(ok), 64'd1);
    tick();
    reset_pulse("rst_dm");

    check("final_imem_left", 64'(imem_q.size()), 64'd0);
    check("final_dump_left", 64'(dump_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
